// File: rtl/addsub_pipe_param.sv
// rtl/addsub_pipe_param.sv - carry-chained pipelined adder/subtractor, one STG_WIDTH slice per stage
// Optional signed-overflow flag: define ADDSUB_PIPE_OVF_EN.
module addsub_pipe_param #(
    parameter int DATA_WIDTH = 64,
    parameter int STG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_sub,
    input  logic                  i_stall,
    input  logic [DATA_WIDTH-1:0] adda,
    input  logic [DATA_WIDTH-1:0] addb,
    output logic [DATA_WIDTH:0]   result,
    output logic                  o_en,
    output logic                  o_ovf
);
    localparam int NUM_STG = DATA_WIDTH / STG_WIDTH;
    localparam int MODE_W  = (NUM_STG > 1) ? NUM_STG - 1 : 1;

    logic                  advance;
    logic                  accept;
    logic [NUM_STG-1:0]    vld;
    logic [NUM_STG-1:0]    cy;
    logic [MODE_W-1:0]     mode;
    logic [DATA_WIDTH-1:0] sum_al;
    logic                  o_en_r;

`ifdef ADDSUB_PIPE_OVF_EN
    logic top_en;
    logic top_sa;
    logic top_sb;
    logic sgn_a;
    logic sgn_b;
    logic ovf_r;
`endif

    assign advance = ~i_stall;
    assign accept  = i_en & ~i_stall;

    // mode[k] belongs to the operation whose valid bit sits in vld[k]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            mode <= '0;
        end else if (advance) begin
            vld[0]  <= accept;
            mode[0] <= i_sub;
            for (int k = 1; k < NUM_STG; k++) vld[k] <= vld[k-1];
            for (int k = 1; k < MODE_W; k++) mode[k] <= mode[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STG; k++) begin : g_slice
        logic [STG_WIDTH-1:0] a_op;
        logic [STG_WIDTH-1:0] b_op;
        logic                 en_stg;
        logic                 sub_stg;
        logic                 cin;
        logic [STG_WIDTH-1:0] s_r;
        logic                 c_r;

        if (k == 0) begin : g_in
            assign a_op    = adda[STG_WIDTH-1:0];
            assign b_op    = addb[STG_WIDTH-1:0];
            assign en_stg  = accept;
            assign sub_stg = i_sub;
            assign cin     = i_sub;
        end else begin : g_skew
            logic [STG_WIDTH-1:0] a_sk [k];
            logic [STG_WIDTH-1:0] b_sk [k];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_sk[j] <= '0;
                        b_sk[j] <= '0;
                    end
                end else if (advance) begin
                    a_sk[0] <= adda[k*STG_WIDTH +: STG_WIDTH];
                    b_sk[0] <= addb[k*STG_WIDTH +: STG_WIDTH];
                    for (int j = 1; j < k; j++) begin
                        a_sk[j] <= a_sk[j-1];
                        b_sk[j] <= b_sk[j-1];
                    end
                end
            end
            assign a_op    = a_sk[k-1];
            assign b_op    = b_sk[k-1];
            assign en_stg  = vld[k-1];
            assign sub_stg = mode[k-1];
            assign cin     = cy[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_r <= '0;
                c_r <= 1'b0;
            end else if (advance && en_stg) begin
                {c_r, s_r} <= {1'b0, a_op} + {1'b0, b_op ^ {STG_WIDTH{sub_stg}}}
                              + {{STG_WIDTH{1'b0}}, cin};
            end
        end
        assign cy[k] = c_r;

        if (k == NUM_STG - 1) begin : g_top
            assign sum_al[k*STG_WIDTH +: STG_WIDTH] = s_r;
`ifdef ADDSUB_PIPE_OVF_EN
            assign top_en = en_stg;
            assign top_sa = a_op[STG_WIDTH-1];
            assign top_sb = b_op[STG_WIDTH-1] ^ sub_stg;
`endif
        end else begin : g_deskew
            localparam int DLY = NUM_STG - 1 - k;
            logic [STG_WIDTH-1:0] d [DLY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < DLY; j++) d[j] <= '0;
                end else if (advance) begin
                    d[0] <= s_r;
                    for (int j = 1; j < DLY; j++) d[j] <= d[j-1];
                end
            end
            assign sum_al[k*STG_WIDTH +: STG_WIDTH] = d[DLY-1];
        end
    end

`ifdef ADDSUB_PIPE_OVF_EN
    // sign bits ride with the top slice so overflow is decided from the same operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_a <= 1'b0;
            sgn_b <= 1'b0;
        end else if (advance && top_en) begin
            sgn_a <= top_sa;
            sgn_b <= top_sb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (advance && vld[NUM_STG-1]) begin
            ovf_r <= (sgn_a == sgn_b) && (sum_al[DATA_WIDTH-1] != sgn_a);
        end
    end
    assign o_ovf = ovf_r;
`else
    assign o_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            o_en_r <= 1'b0;
        end else if (advance) begin
            o_en_r <= vld[NUM_STG-1];
            if (vld[NUM_STG-1]) result <= {cy[NUM_STG-1], sum_al};
        end
    end

    // a result landing just before a stall is held and presented once the stall lifts
    assign o_en = o_en_r & ~i_stall;

endmodule

// File: tb/tb_addsub_pipe_param.sv
// tb/tb_addsub_pipe_param.sv - scoreboard bench for addsub_pipe_param at 64/16 and 32/8
module tb_addsub_pipe_param;
    localparam int NS64 = 4;
    localparam int NS32 = 4;

    typedef struct {
        logic [64:0] res;
        logic        ovf;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sub;
    logic        stall;
    logic [63:0] adda;
    logic [63:0] addb;
    logic [64:0] res64;
    logic [32:0] res32;
    logic        oen64, oen32, ovf64, ovf32;

    int   checks = 0;
    int   errors = 0;
    int   adv = 0;
    exp_t q64[$];
    exp_t q32[$];

    always #5 clk = ~clk;

    addsub_pipe_param #(.DATA_WIDTH(64), .STG_WIDTH(16)) u_dut64 (
        .clk(clk), .rst(rst), .i_en(en), .i_sub(sub), .i_stall(stall),
        .adda(adda), .addb(addb), .result(res64), .o_en(oen64), .o_ovf(ovf64)
    );

    addsub_pipe_param #(.DATA_WIDTH(32), .STG_WIDTH(8)) u_dut32 (
        .clk(clk), .rst(rst), .i_en(en), .i_sub(sub), .i_stall(stall),
        .adda(adda[31:0]), .addb(addb[31:0]), .result(res32), .o_en(oen32), .o_ovf(ovf32)
    );

    // counts pipeline-advancing edges; an op's result is due a fixed number of them after acceptance
    always @(posedge clk) if (!rst && !stall) adv <= adv + 1;

    function automatic exp_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input bit s, input int w, input int tag);
        logic [65:0]        mask, a, b, r;
        logic signed [65:0] sa, sb, tr, lim;
        exp_t               e;
        mask = (66'd1 << w) - 66'd1;
        a    = {2'b00, a_in} & mask;
        b    = {2'b00, b_in} & mask;
        r    = s ? ((66'd1 << w) + a - b) : (a + b);
        e.res = r[64:0];
        sa   = a[w-1] ? $signed(a - (66'd1 << w)) : $signed(a);
        sb   = b[w-1] ? $signed(b - (66'd1 << w)) : $signed(b);
        tr   = s ? (sa - sb) : (sa + sb);
        lim  = $signed(66'd1 << (w - 1));
`ifdef ADDSUB_PIPE_OVF_EN
        e.ovf = (tr >= lim) || (tr < -lim);
`else
        e.ovf = 1'b0;
`endif
        e.tag = tag;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [64:0] got_res, input logic got_ovf, input exp_t e);
        checks++;
        if (got_res !== e.res || got_ovf !== e.ovf || adv != e.tag) begin
            errors++;
            $display("FAIL %s: got res=%h ovf=%b cycle=%0d, want res=%h ovf=%b cycle=%0d",
                     name, got_res, got_ovf, adv, e.res, e.ovf, e.tag);
        end
    endtask

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (oen64) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out64_unexpected: got o_en=1 res=%h, want no output", res64);
                end else cmp("out64", res64, ovf64, q64.pop_front());
            end
            if (oen32) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out32_unexpected: got o_en=1 res=%h, want no output", res32);
                end else cmp("out32", {32'b0, res32}, ovf32, q32.pop_front());
            end
        end
    end

    task automatic drive(input bit e, input bit s, input logic [63:0] a, input logic [63:0] b, input bit st);
        en = e; sub = s; adda = a; addb = b; stall = st;
        if (e && !st) begin
            q64.push_back(model(a, b, s, 64, adv + 1 + NS64));
            q32.push_back(model(a, b, s, 32, adv + 1 + NS32));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic drain;
        for (int i = 0; i < 40; i++) begin
            if (q64.size() == 0 && q32.size() == 0) break;
            idle(1);
        end
        chk("drain64", 65'(q64.size()), 65'd0);
        chk("drain32", 65'(q32.size()), 65'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sub = 1'b0; stall = 1'b0; adda = '0; addb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res64", res64, 65'd0);
        chk("reset_en64", {64'd0, oen64}, 65'd0);
        chk("reset_ovf64", {64'd0, ovf64}, 65'd0);
        chk("reset_res32", {32'd0, res32}, 65'd0);
        chk("reset_en32", {64'd0, oen32}, 65'd0);
        rst = 1'b0;

        // directed corners: full carry ripple, both borrow cases, signed overflow
        drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        drive(1, 1, 64'd5, 64'd7, 0);
        drive(1, 1, 64'd7, 64'd5, 0);
        drive(1, 0, 64'h7FFF_FFFF_7FFF_FFFF, 64'd1, 0);
        drive(1, 1, 64'h8000_0000_8000_0000, 64'd1, 0);
        drive(1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        drive(1, 1, 64'h8000_0000_0000_0000, 64'd1, 0);
        drain();

        // back-to-back alternating modes
        for (int i = 0; i < 8; i++) drive(1, i[0], {$urandom, $urandom}, {$urandom, $urandom}, 0);
        drain();

        // stall with i_en pulsing: those ops must be dropped and in-flight ones delayed
        drive(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        drive(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        for (int i = 0; i < 3; i++) drive(1, i[0], {$urandom, $urandom}, {$urandom, $urandom}, 1);
        idle(1);
        drain();

        // random traffic with random stalls
        for (int i = 0; i < 60; i++)
            drive(($urandom % 4) != 0, $urandom % 2, {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom % 5) == 0);
        drain();

        // reset with three ops in flight
        drive(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        drive(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        en = 1'b0;
        rst = 1'b1;
        q64.delete();
        q32.delete();
        #1;
        chk("midrst_res64", res64, 65'd0);
        chk("midrst_en64", {64'd0, oen64}, 65'd0);
        chk("midrst_res32", {32'd0, res32}, 65'd0);
        chk("midrst_en32", {64'd0, oen32}, 65'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);

        drive(1, 1, 64'd5, 64'd7, 0);
        drive(1, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        drain();
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/addsub_pipe_param.md
# addsub_pipe_param

Parametrised, carry-chained pipelined adder/subtractor for wide operands. It splits `DATA_WIDTH` operands into `STG_WIDTH` slices, resolves one slice per cycle with the carry registered between stages, and issues one result per cycle. It serves datapath blocks that need wide add/compare at high clock rate. It adds a per-operation subtract mode, a global stall, and an optional signed-overflow flag.

## Interface
- `DATA_WIDTH`, 64, operand width; must be an integer multiple of `STG_WIDTH`.
- `STG_WIDTH`, 16, slice width resolved per pipeline stage.
- `NUM_STG` (localparam), `DATA_WIDTH/STG_WIDTH`, stage count and latency; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_en`  in  1  input valid; operands and mode are accepted when `i_en=1` and `i_stall=0`.
- `i_sub`  in  1  mode: 0 = `adda+addb`, 1 = `adda-addb`.
- `i_stall`  in  1  freezes the whole pipeline.
- `adda`  in  `DATA_WIDTH`  operand A.
- `addb`  in  `DATA_WIDTH`  operand B.
- `result`  out  `DATA_WIDTH+1`  MSB = carry-out; lower bits = sum/difference.
- `o_en`  out  1  result valid, one-cycle pulse per accepted operation.
- `o_ovf`  out  1  two's-complement overflow of the `DATA_WIDTH`-bit result; qualified by `o_en`.

## Operation
- Arithmetic: `result = adda + (i_sub ? ~addb : addb) + i_sub`, exactly `DATA_WIDTH+1` bits.
  - Add: `result[DATA_WIDTH]` = unsigned carry.
  - Sub: `result[DATA_WIDTH]=1` means no borrow (`adda ≥ addb` unsigned).
- Slicing: stage k (0..`NUM_STG`-1) adds slice k of A and the (conditionally inverted) slice k of B, plus carry-in.
  - Stage 0 carry-in = `i_sub`; stage k>0 carry-in = registered carry of stage k-1.
- Skew: slice k operands are delayed k registers before stage k. De-skew: the slice k sum is delayed `NUM_STG-1-k` registers so all slices align at the output.
- The mode bit travels with its operation through the valid shift chain; each stage uses the mode of the operation it is processing.
- Valid chain: a `NUM_STG`-deep shift of accepted-valid bits. A stage updates its carry/sum only when its valid bit is set; otherwise it holds.
- Output register: `result` and `o_ovf` update only when the final stage carries a valid operation. Otherwise they hold the last valid values.
- Stall: while `i_stall=1`, every pipeline, skew, de-skew and valid register holds, and `o_en` is driven 0. `i_en` is ignored and the operation is dropped; the source must hold it until the stall ends. When the stall ends, the pipeline resumes with no loss or duplication.
- Reset: all registers clear. `result=0`, `o_en=0`, `o_ovf=0`. In-flight operations are discarded, and no stale `o_en` appears after release.

## Timing
- Latency: an operation accepted at edge N produces `o_en=1` and its `result` valid after edge N+`NUM_STG` (4 cycles at default). Each stall cycle adds exactly one cycle.
- Throughput: one operation per cycle when not stalled.
- `NUM_STG=1`: single registered stage, latency 1.
- Simultaneous `i_en` and `i_stall`: stall wins and the input is not accepted.
- `rst` asserted mid-operation: outputs reach reset values asynchronously, without waiting for a clock edge.

## Configuration
- `ADDSUB_PIPE_OVF_EN` defined:
  - The sign bits of A and effective B are carried alongside the top slice.
  - `o_ovf = (sA == sBeff) && (sR != sA)` for the final `DATA_WIDTH`-bit result.
  - `o_ovf` is registered with `result`.
- `ADDSUB_PIPE_OVF_EN` undefined: the sign pipeline is not built, `o_ovf` is constant 0, and the port remains present.

## Test plan
- Carry across all slices: add `adda=FFFF_FFFF_FFFF_FFFF`, `addb=1` → after 4 cycles `o_en=1`, `result=1_0000_0000_0000_0000`, `o_ovf=0`.
- Subtract, both borrow cases:
  - `5-7` → `result=0_FFFF_FFFF_FFFF_FFFE`.
  - Next cycle `7-5` → `result=1_0000_0000_0000_0002`.
  - Both appear on consecutive `o_en` pulses.
- Back-to-back mixed modes: 8 consecutive random ops with alternating `i_sub` → 8 consecutive `o_en` pulses, in order, each matching the reference model. Repeat with `DATA_WIDTH=32`, `STG_WIDTH=8`.
- Overflow: add `7FFF_FFFF_FFFF_FFFF+1` → `o_ovf=1` with the macro, 0 without. Sub `8000_0000_0000_0000-1` → `o_ovf=1` with the macro.
- Stall: accept 2 ops, hold `i_stall=1` for 3 cycles while pulsing `i_en` → results arrive exactly 3 cycles late, no extra `o_en`, stalled `i_en` dropped.
- Reset mid-flight: accept 3 ops, assert `rst` for 1 cycle at cycle 2 → `result=0` and `o_en=0` immediately, and no `o_en` for those ops afterwards.
